serial_alu_sequencer: RTL
=========================

Name: serial_alu_sequencer

Overview:
- Bit-serial initiator for the existing 1-bit ALU slice. It latches WIDTH-bit operands and an opcode, then drives the slice one bit per clock, LSB first.
- On each of those cycles it captures the slice's result bit and carry, and assembles the WIDTH-bit result.
- The slice's inputs are this block's outputs, and the slice's outputs are this block's inputs. The slice sits purely combinationally between them.
- It sits between the lab top level (switches/registers issuing operations) and the slice.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), width of the bit counter; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  2  opcode: 00 = OR, 01 = ADD, 10 = AND, 11 = NOT A.
- a  in  WIDTH  operand A, latched on accepted start.
- b  in  WIDTH  operand B, latched on accepted start.
- cin  in  1  carry-in for ADD, latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the last bit cycle.
- done  out  1  one-cycle pulse; result and carry_out are valid from this cycle.
- result  out  WIDTH  assembled result; holds until the next accepted start.
- carry_out  out  1  final carry for ADD; 0 for all other opcodes.
- slice_a  out  1  to slice A.
- slice_b  out  1  to slice B.
- slice_cin  out  1  to slice Cin.
- slice_c  out  2  to slice C; equals the latched op.
- slice_result  in  1  from slice Result.
- slice_cout  in  1  from slice Cout.

Behaviour:
- Reset is synchronous: on rst, all outputs are 0 and the state is IDLE.
  - Covers busy, done, result, carry_out, slice_a, slice_b, slice_cin, slice_c.
  - Reset mid-operation aborts it. No done is produced and the partial result is discarded (result = 0).
- FSM states: IDLE, RUN, DONE.
  - IDLE: slice_* outputs are 0. start=1 latches a, b, op, cin into shift/op/carry registers, clears bit_cnt, moves to RUN.
  - RUN: busy=1. Slice drive this cycle:
    - slice_a = a_sh[0], slice_b = b_sh[0], slice_c = op_q.
    - slice_cin = carry_q if op_q == ADD, else 0.
  - RUN, each clock edge:
    - res_sh <= {slice_result, res_sh[WIDTH-1:1]} (LSB-first assembly).
    - a_sh and b_sh shift right by 1.
    - carry_q <= slice_cout if op_q == ADD, else 0.
    - bit_cnt increments.
    - When bit_cnt == WIDTH-1 at the edge, go to DONE.
  - DONE: lasts one cycle.
    - done=1, busy=0.
    - result <= res_sh.
    - carry_out <= carry_q if op_q == ADD, else 0.
    - Next state is IDLE unconditionally.
- Latency: start accepted at edge k. RUN covers cycles k+1 .. k+WIDTH. done is high during cycle k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start is ignored while in RUN or DONE; there is no queuing. start held high in IDLE is accepted once per pass through IDLE.
- The slice is combinational. slice_result/slice_cout are sampled in the same cycle the inputs are driven; no wait states.
- carry_out is forced to 0 for non-ADD ops even if slice_cout toggles.
- Operands on a/b/cin/op may change freely after acceptance.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams OP_OR=2'b00, OP_ADD=2'b01, OP_AND=2'b10, OP_NOTA=2'b11.
  - The FSM state encoding.
- One natural sub-module: shift_reg_piso (parallel-load, right-shift, serial-out), instantiated for the a and b operands.
- The result assembler stays inline.
- The bench pairs this block with the existing 1-bit slice. Mismatches are triaged against a behavioural model of the slice.

Test Plan (WIDTH=8):
- ADD a=0x3C, b=0x0F, cin=0 -> done 9 cycles after start edge; result=0x4B, carry_out=0.
- ADD a=0xFF, b=0x01, cin=0 -> result=0x00, carry_out=1. ADD a=0x00, b=0x00, cin=1 -> result=0x01, carry_out=0.
- OR 0xA5|0x5A -> 0xFF; AND 0xF0&0x3C -> 0x30; NOT A a=0x0F -> 0xF0. carry_out=0 for all three.
- start pulsed during RUN with different operands -> ignored; the first op's result is returned unchanged; exactly one done.
- rst asserted at RUN bit 4 -> next cycle all outputs 0, state IDLE, no done. A new start then completes correctly.
- start held high continuously with ADD 0x01+0x01 -> a done pulse every 10 cycles, result=0x02 each time.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the bit-serial ALU sequencer.
package alu_pkg;
    localparam logic [1:0] OP_OR   = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_NOTA = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;
endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-load, right-shift, serial-out register; sout is always the current LSB.
module shift_reg_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign sout = data_q[0];
endmodule

// File: rtl/serial_alu_sequencer.sv
// Drives a combinational 1-bit ALU slice LSB-first over WIDTH cycles and
// assembles the WIDTH-bit result and final carry.
module serial_alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_c,
    input  logic             slice_result,
    input  logic             slice_cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;

    logic accept, run, is_add, a_bit, b_bit;

    assign accept = (state_q == ST_IDLE) && start;
    assign run    = (state_q == ST_RUN);
    assign is_add = (op_q == OP_ADD);

    shift_reg_piso #(.WIDTH(WIDTH)) u_a_sh (
        .clk   (clk),
        .load  (accept),
        .shift (run),
        .din   (a),
        .sout  (a_bit)
    );

    shift_reg_piso #(.WIDTH(WIDTH)) u_b_sh (
        .clk   (clk),
        .load  (accept),
        .shift (run),
        .din   (b),
        .sout  (b_bit)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        carry_d     = carry_q;
        bit_cnt_d   = bit_cnt_q;
        res_sh_d    = res_sh_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    op_d      = op;
                    carry_d   = cin;
                    bit_cnt_d = '0;
                end
            end
            ST_RUN: begin
                res_sh_d  = {slice_result, res_sh_q[WIDTH-1:1]};
                carry_d   = is_add ? slice_cout : 1'b0;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                // Publish on the last bit edge so result/carry_out are already valid while done is high.
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = ST_DONE;
                    result_d    = res_sh_d;
                    carry_out_d = is_add ? slice_cout : 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            carry_q     <= 1'b0;
            bit_cnt_q   <= '0;
            res_sh_q    <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            bit_cnt_q   <= bit_cnt_d;
            res_sh_q    <= res_sh_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign busy      = run;
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign slice_a   = run & a_bit;
    assign slice_b   = run & b_bit;
    assign slice_cin = run & is_add & carry_q;
    assign slice_c   = run ? op_q : 2'b00;
endmodule
